// File: rtl/song_sequencer_pkg.sv
// Shared audio definitions: note frequencies, ROM word layout and sequencer states.
package song_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } seq_state_e;

  localparam int DUR_MSB = 15;
  localparam int DUR_LSB = 12;
  localparam int HZ_MSB  = 11;

  localparam logic [3:0] END_MARKER = 4'd0;

  localparam logic [11:0] NOTE_4C  = 12'd262;
  localparam logic [11:0] NOTE_4CS = 12'd277;
  localparam logic [11:0] NOTE_4D  = 12'd294;
  localparam logic [11:0] NOTE_4DS = 12'd311;
  localparam logic [11:0] NOTE_4E  = 12'd330;
  localparam logic [11:0] NOTE_4F  = 12'd349;
  localparam logic [11:0] NOTE_4FS = 12'd370;
  localparam logic [11:0] NOTE_4G  = 12'd392;
  localparam logic [11:0] NOTE_4GS = 12'd415;
  localparam logic [11:0] NOTE_4A  = 12'd440;
  localparam logic [11:0] NOTE_4AS = 12'd466;
  localparam logic [11:0] NOTE_4B  = 12'd494;
  localparam logic [11:0] NOTE_5C  = 12'd523;
  localparam logic [11:0] NOTE_5CS = 12'd554;
  localparam logic [11:0] NOTE_5D  = 12'd587;
  localparam logic [11:0] NOTE_5DS = 12'd622;
  localparam logic [11:0] NOTE_5E  = 12'd659;
  localparam logic [11:0] NOTE_5F  = 12'd698;
  localparam logic [11:0] NOTE_5FS = 12'd740;
  localparam logic [11:0] NOTE_5G  = 12'd784;
  localparam logic [11:0] NOTE_5GS = 12'd831;
  localparam logic [11:0] NOTE_5A  = 12'd880;
  localparam logic [11:0] NOTE_5AS = 12'd932;
  localparam logic [11:0] NOTE_5B  = 12'd988;

  // Pack a duration and a frequency into one ROM word.
  function automatic logic [15:0] rom_word(input logic [3:0] dur, input logic [11:0] hz);
    return {dur, hz};
  endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Synchronous melody ROM with one cycle of read latency; SONG selects the table.
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SONG   = 0
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [15:0]       data_o
);

  logic [15:0] word_d;
  logic [15:0] data_q;

  // Table lookup; every unlisted address reads as the end marker.
  always_comb begin
    word_d = rom_word(END_MARKER, 12'd0);
    if (SONG == 0) begin
      case (int'(addr_i))
        0:       word_d = rom_word(4'd2, NOTE_4A);
        1:       word_d = rom_word(4'd1, 12'd0);
        2:       word_d = rom_word(4'd1, NOTE_5C);
        default: word_d = rom_word(END_MARKER, 12'd0);
      endcase
    end else begin
      case (int'(addr_i))
        0:       word_d = rom_word(4'd2, NOTE_4C);
        1:       word_d = rom_word(4'd2, NOTE_4C);
        2:       word_d = rom_word(4'd2, NOTE_4G);
        3:       word_d = rom_word(4'd2, NOTE_4G);
        4:       word_d = rom_word(4'd2, NOTE_4A);
        5:       word_d = rom_word(4'd2, NOTE_4A);
        6:       word_d = rom_word(4'd4, NOTE_4G);
        7:       word_d = rom_word(4'd2, NOTE_4F);
        8:       word_d = rom_word(4'd2, NOTE_4F);
        9:       word_d = rom_word(4'd2, NOTE_4E);
        10:      word_d = rom_word(4'd2, NOTE_4E);
        11:      word_d = rom_word(4'd2, NOTE_4D);
        12:      word_d = rom_word(4'd2, NOTE_4D);
        13:      word_d = rom_word(4'd4, NOTE_4C);
        default: word_d = rom_word(END_MARKER, 12'd0);
      endcase
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    data_q <= word_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Melody sequencer: walks the note ROM and drives the buzzer frequency word.
//
// state | meaning
// IDLE  | silent, waiting for start
// FETCH | ROM samples rom_addr
// LOAD  | ROM word valid; end marker or load note timer
// PLAY  | note timer running, silent for the final GAP_CYCLES
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              loop_i,
  input  logic [15:0]       rom_data_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [11:0]       hz_o,
  output logic              playing_o,
  output logic              done_o
);

  localparam int                CNT_W     = $clog2(15 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0]  UNIT_C    = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_C     = CNT_W'(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  seq_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [11:0]       note_hz_q;
  logic [11:0]       hz_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              playing_q;
  logic              done_q;

  logic [3:0]        dur;
  logic [CNT_W-1:0]  cnt_load_d;

  assign dur        = rom_data_i[DUR_MSB:DUR_LSB];
  assign cnt_load_d = CNT_W'(dur) * UNIT_C - CNT_W'(1);

  // Sequencer FSM with registered outputs; stop beats start beats pause.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      note_hz_q  <= '0;
      hz_q       <= '0;
      rom_addr_q <= '0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q    <= IDLE;
        hz_q       <= '0;
        rom_addr_q <= '0;
        playing_q  <= 1'b0;
      end else if (start_i) begin
        state_q    <= FETCH;
        hz_q       <= '0;
        rom_addr_q <= '0;
        playing_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            hz_q <= '0;
          end
          FETCH: begin
            hz_q    <= '0;
            state_q <= LOAD;
          end
          LOAD: begin
            hz_q <= '0;
            if (dur == END_MARKER) begin
              done_q     <= 1'b1;
              rom_addr_q <= '0;
              if (loop_i) begin
                state_q <= FETCH;
              end else begin
                state_q   <= IDLE;
                playing_q <= 1'b0;
              end
            end else begin
              note_hz_q <= rom_data_i[HZ_MSB:0];
              cnt_q     <= cnt_load_d;
              state_q   <= PLAY;
            end
          end
          PLAY: begin
            if (pause_i) begin
              hz_q <= '0;
            end else begin
              hz_q <= (cnt_q >= GAP_C) ? note_hz_q : '0;
              if (cnt_q == '0) begin
                // Incrementing past the last address wraps to 0 and ends the song.
                rom_addr_q <= rom_addr_q + 1'b1;
                if (rom_addr_q == ADDR_LAST) begin
                  done_q <= 1'b1;
                  if (loop_i) begin
                    state_q <= FETCH;
                  end else begin
                    state_q   <= IDLE;
                    playing_q <= 1'b0;
                  end
                end else begin
                  state_q <= FETCH;
                end
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign hz_o       = hz_q;
  assign playing_o  = playing_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: an expected per-cycle output trace is built
// from the song table, collapsed into runs of {playing,hz} and done positions,
// and a monitor compares the DUT's runs and done pulses against those queues.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  localparam int UNIT  = 10;
  localparam int GAP   = 2;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0, loop_lv = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0] rom_data, hw_data, tb_rom_q;
  logic [11:0] hz;
  logic playing, done;
  bit use_hw = 1'b1;
  logic [15:0] mem [DEPTH];

  always #5 clk = ~clk;

  song_rom #(.ADDR_W(AW), .SONG(0)) u_rom (.clk_i(clk), .addr_i(rom_addr), .data_o(hw_data));

  always @(posedge clk) tb_rom_q <= mem[rom_addr];
  assign rom_data = use_hw ? hw_data : tb_rom_q;

  song_sequencer #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
    .loop_i(loop_lv), .rom_data_i(rom_data), .rom_addr_o(rom_addr), .hz_o(hz),
    .playing_o(playing), .done_o(done));

  typedef struct { logic [11:0] hz; bit done; bit play; bit tag; } samp_t;
  typedef struct { logic [12:0] val; int len; } run_t;

  samp_t tr[$];
  run_t  run_q[$];
  int    done_q[$];
  bit    pz[];

  int n_pass = 0, n_total = 0;
  bit mon_en = 1'b0;
  int cyc_idx = 0, cur_len = 0, tone_cnt = 0;
  logic [12:0] cur_val, mv;
  run_t mon_r;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected trace: sample k is the output after the k-th edge, edge 0 seeing start.
  // tag marks samples produced while PLAY was active, i.e. where pause would freeze.
  task automatic build_trace(input bit lp, input int cap);
    int addr = 0;
    bit prev_play = 0, pend = 0, fin = 0;
    int d;
    logic [11:0] f;
    tr.delete();
    while (tr.size() < cap && !fin) begin
      d = int'(mem[addr][15:12]);
      f = mem[addr][11:0];
      if (d == 0) begin
        tr.push_back('{12'd0, pend, 1'b1, prev_play});
        pend = 0;
        tr.push_back('{12'd0, 1'b0, 1'b1, 1'b0});
        addr = 0;
        prev_play = 0;
        if (lp) pend = 1;
        else begin tr.push_back('{12'd0, 1'b1, 1'b0, 1'b0}); fin = 1; end
      end else begin
        tr.push_back('{12'd0, pend, 1'b1, prev_play});
        pend = 0;
        tr.push_back('{12'd0, 1'b0, 1'b1, 1'b0});
        tr.push_back('{12'd0, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < d * UNIT - GAP; i++) tr.push_back('{f, 1'b0, 1'b1, 1'b1});
        for (int i = 0; i < GAP - 1; i++) tr.push_back('{12'd0, 1'b0, 1'b1, 1'b1});
        prev_play = 1;
        if (addr == DEPTH - 1) begin
          addr = 0;
          if (lp) pend = 1;
          else begin tr.push_back('{12'd0, 1'b1, 1'b0, 1'b1}); fin = 1; end
        end else addr++;
      end
    end
    while (tr.size() < cap) tr.push_back('{12'd0, 1'b0, 1'b0, 1'b0});
    // A pause edge during PLAY inserts one silent cycle and delays everything after it.
    for (int k = 0; k < cap; k++)
      if (pz[k] && k < tr.size() && tr[k].tag) tr.insert(k, '{12'd0, 1'b0, 1'b1, 1'b1});
    while (tr.size() > cap) void'(tr.pop_back());
    run_q.delete();
    done_q.delete();
    begin
      run_t r;
      r.val = {tr[0].play, tr[0].hz};
      r.len = 0;
      for (int k = 0; k < cap; k++) begin
        if ({tr[k].play, tr[k].hz} != r.val) begin
          run_q.push_back(r);
          r.val = {tr[k].play, tr[k].hz};
          r.len = 0;
        end
        r.len++;
        if (tr[k].done) done_q.push_back(k);
      end
      run_q.push_back(r);
    end
  endtask

  // Monitor: closes runs of {playing,hz} and checks done positions.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      mv = {playing, hz};
      if (cyc_idx == 0) begin
        cur_val = mv;
        cur_len = 1;
      end else if (mv == cur_val) begin
        cur_len++;
      end else begin
        if (run_q.size() == 0) chk("run_extra", run_q.size(), 1);
        else begin
          mon_r = run_q.pop_front();
          chk("run_val", cur_val, mon_r.val);
          chk("run_len", cur_len, mon_r.len);
        end
        cur_val = mv;
        cur_len = 1;
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_extra", done_q.size(), 1);
        else chk("done_idx", cyc_idx, done_q.pop_front());
      end
      if (hz == NOTE_4A) tone_cnt++;
      cyc_idx++;
    end
  end

  task automatic run_phase(input bit lp, input int cap, input bit do_stop, input bit chk_addr);
    build_trace(lp, cap);
    if (do_stop) begin
      @(negedge clk) stop = 1'b1;
      @(negedge clk) stop = 1'b0;
    end
    loop_lv = lp;
    cyc_idx = 0;
    tone_cnt = 0;
    for (int k = 0; k < cap; k++) begin
      @(negedge clk);
      if (k == 1 && chk_addr) chk("restart_addr", rom_addr, 0);
      start = (k == 0);
      pause = pz[k];
      if (k == 0) mon_en = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    mon_en = 1'b0;
    if (run_q.size() == 0) chk("run_last_missing", run_q.size(), 1);
    else begin
      mon_r = run_q.pop_front();
      chk("run_last_val", cur_val, mon_r.val);
      chk("run_last_len", cur_len, mon_r.len);
    end
    chk("runs_left", run_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  task automatic clear_pause(input int cap);
    pz = new[cap];
    foreach (pz[i]) pz[i] = 1'b0;
  endtask

  task automatic load_plan_song();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    mem[0] = {4'd2, 12'd440};
    mem[1] = {4'd1, 12'd0};
    mem[2] = {4'd1, 12'd523};
  endtask

  task automatic rand_song(input bit no_end);
    int d;
    logic [11:0] f;
    for (int i = 0; i < DEPTH; i++) begin
      d = no_end ? $urandom_range(1, 3) : $urandom_range(0, 3);
      if (i == 0 && d == 0) d = 1;
      f = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      mem[i] = {4'(d), f};
    end
  endtask

  initial begin
    int dcnt, cap, s;
    bit lp;
    load_plan_song();
    repeat (3) @(negedge clk);
    chk("reset_hz", hz, 0);
    chk("reset_playing", playing, 0);
    chk("reset_done", done, 0);
    chk("reset_addr", rom_addr, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_playing", playing, 0);

    // Basic play of the reference song.
    clear_pause(60);
    run_phase(1'b0, 60, 1'b0, 1'b0);
    chk("basic_tone_cnt", tone_cnt, 18);
    chk("basic_end_addr", rom_addr, 0);
    chk("basic_end_playing", playing, 0);

    // Looping through the end marker.
    clear_pause(120);
    run_phase(1'b1, 120, 1'b1, 1'b0);

    // Pause for 7 clocks from the 5th audible cycle of the first note.
    clear_pause(70);
    for (int i = 7; i < 14; i++) pz[i] = 1'b1;
    run_phase(1'b0, 70, 1'b1, 1'b0);
    chk("pause_tone_cnt", tone_cnt, 18);

    // Stop mid-note.
    loop_lv = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    chk("stop_pre_hz", hz, 440);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk("stop_hz", hz, 0);
    chk("stop_playing", playing, 0);
    chk("stop_addr", rom_addr, 0);
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("stop_no_done", dcnt, 0);

    // start and stop together while playing.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_playing", playing, 0);
    chk("startstop_hz", hz, 0);
    repeat (5) @(negedge clk);
    chk("startstop_stays_idle", playing, 0);

    // Restart during the second note.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (30) @(negedge clk);
    chk("restart_pre_addr", rom_addr, 1);
    clear_pause(60);
    run_phase(1'b0, 60, 1'b0, 1'b1);

    // Randomized songs, loop and pause windows against the bench ROM.
    use_hw = 1'b0;
    for (int p = 0; p < 10; p++) begin
      rand_song(p < 2);
      lp = (p == 1) ? 1'b1 : ((p == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      cap = lp ? $urandom_range(150, 300) : 300;
      clear_pause(cap);
      repeat ($urandom_range(0, 2)) begin
        s = $urandom_range(3, 200);
        for (int i = s; i < s + $urandom_range(1, 6) && i < cap; i++) pz[i] = 1'b1;
      end
      run_phase(lp, cap, 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of the third note.
    use_hw = 1'b1;
    load_plan_song();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) begin stop = 1'b0; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_pre_hz", hz, 523);
    chk("rst_pre_addr", rom_addr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_hz", hz, 0);
    chk("rst_async_playing", playing, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_addr", rom_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_after_playing", playing, 0);
    chk("rst_after_hz", hz, 0);
    chk("rst_after_addr", rom_addr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
